// File: rtl/ps2_pkg.sv
// PS/2 host controller shared definitions.
// Register map, bit positions, FSM encoding.
package ps2_pkg;

  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  localparam int B_RXEN  = 7;
  localparam int B_IE    = 6;
  localparam int B_OVR   = 5;
  localparam int B_FULL  = 4;
  localparam int B_NE    = 3;
  localparam int B_FLUSH = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  function automatic logic [2:0] sat_cnt(
    input logic [4:0] c
  );
    return (c > 5'd7) ? 3'd7 : c[2:0];
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// PS/2 receive FIFO, power-of-two depth.
// Pop is judged on pre-cycle state; flush wins.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd;
  logic          wr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign head  = mem[rd_ptr];

  // pointer and occupancy update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (wr & ~flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host controller: bus regs, FSM, irq.
// Side effects fire once, on IDLE->ACK.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_valid,
  input  logic [7:0] dec_data,
  output logic       dec_int_clear,
  output logic       ps2_clk_inhibit,
  input  logic       cs,
  input  logic       rw,
  input  logic       addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       dtack,
  output logic       irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state;
  logic [1:0]    state_d;
  logic          rxen;
  logic          ie;
  logic          ovr;
  logic [7:0]    f_head;
  logic [CW-1:0] f_cnt;
  logic          f_full;
  logic          f_empty;
  logic          start;
  logic          pop;
  logic          pop_ok;
  logic          ctrl_wr;
  logic          flush;
  logic          push;
  logic          ovr_set;
  logic [7:0]    status;
  logic [7:0]    rd_mux;
  logic          unused_wd;

  assign unused_wd = ^wdata[4:1];

  assign start   = (state == ST_IDLE) & cs;
  assign pop     = start & rw & (addr == ADDR_DATA);
  assign pop_ok  = pop & ~f_empty;
  assign ctrl_wr = start & ~rw & (addr == ADDR_STAT);
  assign flush   = ctrl_wr & wdata[B_FLUSH];
  assign push    = dec_valid & rxen;
  assign ovr_set = push & f_full & ~pop_ok & ~flush;
  assign dtack   = (state != ST_IDLE);

  assign status = {rxen, ie, ovr, f_full,
                   ~f_empty, sat_cnt(5'(f_cnt))};
  assign rd_mux = (addr == ADDR_STAT) ? status :
                  (f_empty ? 8'h00 : f_head);

  ps2_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (dec_data),
    .head  (f_head),
    .count (f_cnt),
    .full  (f_full),
    .empty (f_empty)
  );

  // bus handshake next state
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (cs) state_d = ST_ACK;
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: if (!cs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // bus state and read data latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rdata <= 8'h00;
    end else begin
      state <= state_d;
      if (start)
        rdata <= rw ? rd_mux : 8'h00;
      else if (state_d == ST_IDLE)
        rdata <= 8'h00;
    end
  end

  // control/status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxen <= 1'b0;
      ie   <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rxen <= wdata[B_RXEN];
        ie   <= wdata[B_IE];
        if (wdata[B_OVR]) ovr <= 1'b0;
      end
      if (ovr_set) ovr <= 1'b1;
    end
  end

  // registered side-band outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_int_clear   <= 1'b0;
      irq             <= 1'b0;
      ps2_clk_inhibit <= 1'b1;
    end else begin
      dec_int_clear   <= dec_valid | flush;
      irq             <= ie & (~f_empty | ovr);
      ps2_clk_inhibit <= ~rxen | f_full;
    end
  end

endmodule

// File: doc/ps2_host_ctrl.md
PS2_HOST_CTRL -- requirements
Module: ps2_host_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port dec_valid  input  1  one-cycle pulse from the PS/2 decoder, scan code present.
REQ-005 SHALL have port dec_data  input  8  decoder scan code, qualified by dec_valid.
REQ-006 SHALL have port dec_int_clear  output  1  one-cycle pulse clearing the decoder interrupt.
REQ-007 SHALL have port ps2_clk_inhibit  output  1  high = hold the PS/2 clock line low (host inhibit).
REQ-008 SHALL have port cs  input  1  CPU bus chip select, level, held until dtack is seen.
REQ-009 SHALL have port rw  input  1  1 = read, 0 = write; sampled with cs.
REQ-010 SHALL have port addr  input  1  0 = DATA register, 1 = STATUS/CTRL register.
REQ-011 SHALL have port wdata  input  8  write data.
REQ-012 SHALL have port rdata  output  8  read data, valid while dtack is high.
REQ-013 SHALL have port dtack  output  1  bus acknowledge.
REQ-014 SHALL have port irq  output  1  level interrupt request to the CPU.

Function
REQ-015 SHALL accept dec_valid into the FIFO only when RXEN=1 and the FIFO is not full; a dec_valid with RXEN=0 SHALL be dropped without setting OVR.
REQ-016 SHALL, on dec_valid with RXEN=1 and FIFO full, drop the byte and set sticky OVR.
REQ-017 SHALL pulse dec_int_clear in the cycle after every accepted or dropped dec_valid, and in the cycle after a flush.
REQ-018 SHALL run the bus FSM IDLE -> ACK -> HOLD -> IDLE: IDLE->ACK when cs=1; ACK->HOLD unconditionally; HOLD->IDLE when cs=0.
REQ-019 SHALL drive dtack=1 in ACK and HOLD, so dtack rises exactly one cycle after cs is first sampled high.
REQ-020 SHALL apply register side effects exactly once per cs assertion, on the IDLE->ACK transition.
REQ-021 SHALL, on a DATA read, return the FIFO head and pop it; an empty FIFO SHALL return 0x00 with no pop.
REQ-022 SHALL, on a STATUS read, return [7]RXEN [6]IE [5]OVR [4]FULL [3]NONEMPTY [2:0]COUNT (saturates at 7).
REQ-023 SHALL, on a CTRL write, load RXEN=wdata[7] and IE=wdata[6], clear OVR if wdata[5]=1, and flush the FIFO if wdata[0]=1.
REQ-024 SHALL acknowledge a DATA write normally and otherwise ignore it.
REQ-025 SHALL hold rdata stable from ACK through HOLD and drive 0x00 in IDLE.
REQ-026 SHALL evaluate a pop against the pre-cycle FIFO state: push and pop together on a full FIFO keep COUNT at FIFO_DEPTH with no overrun; on an empty FIFO they return 0x00 and leave COUNT=1.
REQ-027 SHALL let a flush win over a simultaneous push: the byte is discarded and OVR is unchanged.
REQ-028 SHALL wrap FIFO pointers modulo FIFO_DEPTH and keep count width clog2(FIFO_DEPTH)+1.
REQ-029 SHALL drive irq = IE & (NONEMPTY | OVR), registered.
REQ-030 SHALL drive ps2_clk_inhibit = ~RXEN | FULL, registered.

Reset
REQ-031 SHALL, on rst_n=0, immediately force FIFO empty, RXEN=0, IE=0, OVR=0, FSM=IDLE, dtack=0, rdata=0x00, irq=0, dec_int_clear=0, ps2_clk_inhibit=1.
REQ-032 SHALL abort a bus cycle in progress when reset is asserted, with no side effect; after release a still-asserted cs SHALL start a new cycle.

Structure
REQ-033 SHALL place register addresses, status/ctrl bit positions, the FIFO_DEPTH default and the bus FSM state encoding in the shared package ps2_pkg.
REQ-034 SHALL implement the FIFO as one sub-module, ps2_rx_fifo (push, pop, flush, head, count, full, empty), with the controller holding registers, bus FSM and interrupt logic.

Verification
REQ-035 SHALL cover: reset release, write CTRL 0xC0, push 0x1C -> irq=1, STATUS=0xC9, DATA read=0x1C, then irq=0 and STATUS=0xC0.
REQ-036 SHALL cover: push 5 bytes 0x01..0x05 with depth 4 -> OVR=1, FULL=1, ps2_clk_inhibit=1, reads return 0x01..0x04, then 0x00.
REQ-037 SHALL cover: cs held high for 10 cycles on a DATA read with 2 entries -> dtack rises in cycle 2, exactly one pop, COUNT=1.
REQ-038 SHALL cover: a DATA read on a full FIFO with dec_valid in the IDLE->ACK cycle -> COUNT stays 4 and OVR=0.
REQ-039 SHALL cover: CTRL write 0xE1 with dec_valid in the same cycle -> FIFO empty, OVR=0, dec_int_clear pulses once per event.
REQ-040 SHALL cover: rst_n low in HOLD with 3 entries -> dtack=0 and COUNT=0 immediately, and no pop occurs after release.
